// File: rtl/tg_uart_bridge.sv
// tg_uart_bridge: buffered host-side initiator for the 8N1 serial controller
// io port. A TX FIFO feeds controller writes whenever it is idle; an RX FIFO
// (first-word-fall-through) collects bytes read back from the controller.
// Optional feature macro: TG_UART_BRIDGE_RXOVR_EN -- always drain the
// controller and drop bytes arriving at a full RX FIFO (sticky rx_overrun).
module tg_uart_bridge #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  io_clk,
   input  logic                  io_rst,
   input  logic [7:0]            tx_wdata,
   input  logic                  tx_push,
   output logic                  tx_full,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic [7:0]            rx_rdata,
   input  logic                  rx_pop,
   output logic                  rx_empty,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic                  rx_overrun,
   input  logic                  rx_ovr_clr,
   output logic [7:0]            u_wdata,
   input  logic [7:0]            u_rdata,
   output logic                  u_req,
   output logic                  u_wr,
   input  logic                  u_ack,
   input  logic                  u_tx_busy,
   input  logic                  u_rx_ready
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TXWR   = 2'd1,
      TXHOLD = 2'd2,
      RXRD   = 2'd3
   } state_t;

   state_t                 state_reg, state_next;
   logic                   wdata_load;
   logic [7:0]             u_wdata_reg;

   logic [7:0]             tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  tx_wr_ptr_reg, tx_rd_ptr_reg;
   logic [DEPTH_LOG2:0]    tx_count_reg, tx_count_next;

   logic [7:0]             rx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  rx_wr_ptr_reg, rx_rd_ptr_reg;
   logic [DEPTH_LOG2:0]    rx_count_reg, rx_count_next;

   logic                   rx_full;
   logic                   tx_pop, tx_push_ok;
   logic                   rx_pop_ok, rx_push_req, rx_push_ok, rx_drop;
   logic                   rd_permit;

   // A push into a full FIFO is accepted only when the head leaves on the
   // same edge, so a simultaneous push and pop at full keeps the count.
   assign tx_full     = (tx_count_reg == DEPTH_CNT);
   assign rx_full     = (rx_count_reg == DEPTH_CNT);
   assign rx_empty    = (rx_count_reg == '0);
   assign tx_pop      = (state_reg == TXWR) && u_ack;
   assign tx_push_ok  = tx_push && (!tx_full || tx_pop);
   assign rx_pop_ok   = rx_pop && !rx_empty;
   assign rx_push_req = (state_reg == RXRD) && u_ack;
   assign rx_push_ok  = rx_push_req && (!rx_full || rx_pop_ok);
   assign rx_drop     = rx_push_req && !rx_push_ok;

   assign tx_count    = tx_count_reg;
   assign rx_count    = rx_count_reg;
   assign u_wdata     = u_wdata_reg;
   assign rx_rdata    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];

`ifdef TG_UART_BRIDGE_RXOVR_EN
   // Controller is always drained; a full RX FIFO drops the byte instead.
   assign rd_permit = 1'b1;

   // Sticky overrun flag; a drop in the same cycle as a clear wins.
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         rx_overrun <= 1'b0;
      end else if (rx_drop) begin
         rx_overrun <= 1'b1;
      end else if (rx_ovr_clr) begin
         rx_overrun <= 1'b0;
      end
   end
`else
   // Full RX FIFO backpressures by leaving the byte in the controller.
   logic unused_ovr;
   assign rd_permit  = !rx_full;
   assign rx_overrun = 1'b0;
   assign unused_ovr = rx_ovr_clr ^ rx_drop;
`endif

   // Next-state and handshake decode; u_req/u_wr depend on state only.
   always_comb begin
      state_next = state_reg;
      wdata_load = 1'b0;
      u_req      = 1'b0;
      u_wr       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (u_rx_ready && rd_permit) begin
               state_next = RXRD;
            end else if ((tx_count_reg != '0) && !u_tx_busy) begin
               state_next = TXWR;
               wdata_load = 1'b1;
            end
         end
         TXWR: begin
            u_req = 1'b1;
            u_wr  = 1'b1;
            if (u_ack) begin
               state_next = TXHOLD;
            end
         end
         // Gap cycle while the controller raises u_tx_busy.
         TXHOLD: begin
            state_next = IDLE;
         end
         RXRD: begin
            u_req = 1'b1;
            if (u_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Write data is captured from the TX head when a write is issued and held.
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         u_wdata_reg <= 8'h00;
      end else if (wdata_load) begin
         u_wdata_reg <= tx_mem[tx_rd_ptr_reg];
      end
   end

   // Occupancy arithmetic for both FIFOs.
   always_comb begin
      tx_count_next = tx_count_reg;
      rx_count_next = rx_count_reg;
      case ({tx_push_ok, tx_pop})
         2'b10:   tx_count_next = tx_count_reg + CNT_ONE;
         2'b01:   tx_count_next = tx_count_reg - CNT_ONE;
         default: tx_count_next = tx_count_reg;
      endcase
      case ({rx_push_ok, rx_pop_ok})
         2'b10:   rx_count_next = rx_count_reg + CNT_ONE;
         2'b01:   rx_count_next = rx_count_reg - CNT_ONE;
         default: rx_count_next = rx_count_reg;
      endcase
   end

   // TX FIFO pointers and count.
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         tx_wr_ptr_reg <= '0;
         tx_rd_ptr_reg <= '0;
         tx_count_reg  <= '0;
      end else begin
         if (tx_push_ok) begin
            tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
         end
         if (tx_pop) begin
            tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
         end
         tx_count_reg <= tx_count_next;
      end
   end

   // RX FIFO pointers and count.
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         rx_wr_ptr_reg <= '0;
         rx_rd_ptr_reg <= '0;
         rx_count_reg  <= '0;
      end else begin
         if (rx_push_ok) begin
            rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
         end
         if (rx_pop_ok) begin
            rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
         end
         rx_count_reg <= rx_count_next;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge io_clk) begin
      if (tx_push_ok) begin
         tx_mem[tx_wr_ptr_reg] <= tx_wdata;
      end
      if (rx_push_ok) begin
         rx_mem[rx_wr_ptr_reg] <= u_rdata;
      end
   end

endmodule

// File: tb/tb_tg_uart_bridge.sv
// Testbench for tg_uart_bridge: the bench plays the serial controller and
// keeps queue-based models of both FIFOs, checked every cycle.
module tb_tg_uart_bridge;

   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;

   logic           io_clk = 1'b0;
   logic           io_rst = 1'b1;
   logic [7:0]     tx_wdata = '0;
   logic           tx_push = 1'b0;
   logic           tx_full;
   logic [DL2:0]   tx_count;
   logic [7:0]     rx_rdata;
   logic           rx_pop = 1'b0;
   logic           rx_empty;
   logic [DL2:0]   rx_count;
   logic           rx_overrun;
   logic           rx_ovr_clr = 1'b0;
   logic [7:0]     u_wdata;
   logic [7:0]     u_rdata = '0;
   logic           u_req;
   logic           u_wr;
   logic           u_ack = 1'b0;
   logic           u_tx_busy = 1'b0;
   logic           u_rx_ready = 1'b0;

   tg_uart_bridge #(.DEPTH_LOG2(DL2)) dut (
      .io_clk(io_clk), .io_rst(io_rst),
      .tx_wdata(tx_wdata), .tx_push(tx_push), .tx_full(tx_full), .tx_count(tx_count),
      .rx_rdata(rx_rdata), .rx_pop(rx_pop), .rx_empty(rx_empty), .rx_count(rx_count),
      .rx_overrun(rx_overrun), .rx_ovr_clr(rx_ovr_clr),
      .u_wdata(u_wdata), .u_rdata(u_rdata), .u_req(u_req), .u_wr(u_wr),
      .u_ack(u_ack), .u_tx_busy(u_tx_busy), .u_rx_ready(u_rx_ready)
   );

   always #5 io_clk = ~io_clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0] m_tx[$];
   logic [7:0] m_rx[$];
   logic [7:0] sent[$];
   logic       m_ovr = 1'b0;
   // controller model state
   logic       ctl_rdy = 1'b0;
   logic [7:0] ctl_byte = '0;
   logic       ctl_pend = 1'b0;
   int         busy_cnt = 0;
   int         busy_len = 3;
   logic       busy_hold = 1'b0;
   int         ack_mode = 1;   // 0 none, 1 zero-wait, 2 random
   logic       prev_wrreq = 1'b0;
   int         n_reads = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: snapshot what the DUT sees, advance, update models, compare.
   task automatic tick();
      logic wr_done, rd_done, pop_ok, tx_was_full, rx_was_full, busy_true;
      logic psh, clr, rdy, drop;
      logic [7:0] wd, twd;
      wr_done     = u_req && u_wr && u_ack;
      rd_done     = u_req && !u_wr && u_ack;
      wd          = u_wdata;
      twd         = tx_wdata;
      psh         = tx_push;
      clr         = rx_ovr_clr;
      rdy         = ctl_rdy;
      pop_ok      = rx_pop && (m_rx.size() != 0);
      tx_was_full = (m_tx.size() == DEPTH);
      rx_was_full = (m_rx.size() == DEPTH);
      busy_true   = ctl_pend || u_tx_busy;
      drop        = 1'b0;
      @(posedge io_clk);
      #1;
      // TX reference
      if (wr_done) begin
         if (m_tx.size() == 0) check("tx_spurious", 1, 0);
         else check("tx_byte", wd, m_tx.pop_front());
         sent.push_back(wd);
      end
      if (psh && (!tx_was_full || wr_done)) m_tx.push_back(twd);
      // controller busy lags the accepted write by one cycle
      if (busy_cnt > 0) busy_cnt--;
      if (ctl_pend) busy_cnt = busy_len;
      ctl_pend = wr_done;
      if (u_req && u_wr && !prev_wrreq) check("wr_while_busy", busy_true, 0);
      // RX reference
      if (pop_ok) void'(m_rx.pop_front());
      if (rd_done) begin
         n_reads++;
         check("rd_ready", rdy, 1);
         if (!rx_was_full || pop_ok) m_rx.push_back(ctl_byte);
         else begin
`ifdef TG_UART_BRIDGE_RXOVR_EN
            drop = 1'b1;
`else
            check("rd_into_full", 1, 0);
`endif
         end
         ctl_rdy = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      // output comparisons
      check("tx_count", tx_count, m_tx.size());
      check("tx_full", tx_full, m_tx.size() == DEPTH);
      check("rx_count", rx_count, m_rx.size());
      check("rx_empty", rx_empty, m_rx.size() == 0);
      if (m_rx.size() != 0) check("rx_rdata", rx_rdata, m_rx[0]);
      check("rx_overrun", rx_overrun, m_ovr);
      // next-cycle drive
      prev_wrreq = u_req && u_wr;
      tx_push    = 1'b0;
      rx_pop     = 1'b0;
      rx_ovr_clr = 1'b0;
      u_tx_busy  = busy_hold || (busy_cnt > 0);
      u_rx_ready = ctl_rdy;
      u_rdata    = ctl_byte;
      u_ack      = u_req && ((ack_mode == 1) || ((ack_mode == 2) && ($urandom_range(0, 2) == 0)));
   endtask

   task automatic push(input logic [7:0] b);
      tx_wdata = b;
      tx_push  = 1'b1;
      tick();
   endtask

   task automatic arrive(input logic [7:0] b);
      ctl_rdy    = 1'b1;
      ctl_byte   = b;
      u_rx_ready = 1'b1;
      u_rdata    = b;
   endtask

   task automatic set_hold(input logic h);
      busy_hold = h;
      u_tx_busy = h || (busy_cnt > 0);
   endtask

   task automatic drain(input int lim);
      int i;
      for (i = 0; i < lim; i++) begin
         if (m_tx.size() == 0 && m_rx.size() == 0 && !ctl_rdy && !ctl_pend &&
             busy_cnt == 0 && !u_req) break;
         if (m_rx.size() != 0) rx_pop = 1'b1;
         tick();
      end
      check("drain_timeout", i < lim, 1);
      tick();
   endtask

   task automatic model_reset();
      m_tx.delete(); m_rx.delete();
      m_ovr = 0; ctl_rdy = 0; ctl_pend = 0; busy_cnt = 0; busy_hold = 0; prev_wrreq = 0;
      tx_push = 0; rx_pop = 0; rx_ovr_clr = 0; tx_wdata = 0;
      u_ack = 0; u_tx_busy = 0; u_rx_ready = 0; u_rdata = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_u_req"}, u_req, 0);
      check({tag, "_u_wr"}, u_wr, 0);
      check({tag, "_u_wdata"}, u_wdata, 0);
      check({tag, "_tx_full"}, tx_full, 0);
      check({tag, "_tx_count"}, tx_count, 0);
      check({tag, "_rx_empty"}, rx_empty, 1);
      check({tag, "_rx_count"}, rx_count, 0);
      check({tag, "_rx_rdata"}, rx_rdata, 0);
      check({tag, "_rx_overrun"}, rx_overrun, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b, c;
      logic [7:0] burst [3];
      int i;
      burst[0] = 8'h55; burst[1] = 8'hA3; burst[2] = 8'h0F;

      // reset state
      model_reset();
      #12;
      check_reset_outputs("rst0");
      @(posedge io_clk); #1;
      io_rst = 1'b0;

      // TX latency with zero-wait ack
      ack_mode = 1;
      busy_len = 3;
      b = 8'($urandom);
      push(b);
      check("lat_req_n", u_req, 0);
      tick();
      check("lat_req", u_req, 1);
      check("lat_wr", u_wr, 1);
      check("lat_wdata", u_wdata, b);
      tick();
      check("lat_txcnt", tx_count, 0);
      check("lat_hold", u_req, 0);
      drain(50);

      // RX path
      n_reads = 0;
      arrive(8'h7E);
      tick();
      check("rx_req", u_req, 1);
      check("rx_dir", u_wr, 0);
      tick();
      check("rx_data", rx_rdata, 8'h7E);
      check("rx_cnt", rx_count, 1);
      repeat (3) tick();
      check("rx_single", n_reads, 1);
      rx_pop = 1'b1;
      tick();
      check("rx_popped", rx_empty, 1);

      // RX has priority over pending TX
      set_hold(1);
      push(8'($urandom));
      push(8'($urandom));
      arrive(8'($urandom));
      set_hold(0);
      tick();
      check("prio_req", u_req, 1);
      check("prio_dir", u_wr, 0);
      drain(100);

      // TX burst with long busy periods
      sent.delete();
      busy_len = 10;
      for (i = 0; i < 3; i++) push(burst[i]);
      drain(200);
      check("burst_n", sent.size(), 3);
      for (i = 0; i < 3 && i < sent.size(); i++) check("burst_byte", sent[i], burst[i]);

      // full, dropped push, push+pop at full, wrap order
      busy_len = 3;
      set_hold(1);
      for (i = 0; i < DEPTH; i++) push(8'($urandom));
      check("full_flag", tx_full, 1);
      push(8'($urandom));
      check("full_drop", tx_count, DEPTH);
      set_hold(0);
      for (i = 0; i < 20 && !(u_req && u_wr); i++) tick();
      check("full_wr_seen", u_req && u_wr, 1);
      push(8'($urandom));
      check("pushpop_cnt", tx_count, DEPTH);
      drain(200);

      // RX full followed by 0x99
      for (i = 0; i < DEPTH; i++) begin
         arrive(8'($urandom));
         tick();
         tick();
      end
      check("rxfull_cnt", rx_count, DEPTH);
      arrive(8'h99);
      repeat (4) tick();
`ifdef TG_UART_BRIDGE_RXOVR_EN
      check("ovr_read", u_rx_ready, 0);
      check("ovr_flag", rx_overrun, 1);
      check("ovr_cnt", rx_count, DEPTH);
      rx_ovr_clr = 1'b1;
      tick();
      check("ovr_clr", rx_overrun, 0);
`else
      check("bp_ready", u_rx_ready, 1);
      check("bp_req", u_req, 0);
      check("bp_flag", rx_overrun, 0);
      rx_pop = 1'b1;
      tick();
      repeat (3) tick();
      check("bp_read", u_rx_ready, 0);
      check("bp_cnt", rx_count, DEPTH);
`endif
      drain(100);

      // randomized traffic
      ack_mode = 2;
      for (i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            tx_wdata = 8'($urandom);
            tx_push  = 1'b1;
         end
         rx_pop     = ($urandom_range(0, 9) < 3);
         rx_ovr_clr = ($urandom_range(0, 15) == 0);
         if (!ctl_rdy && $urandom_range(0, 3) == 0) arrive(8'($urandom));
         if ($urandom_range(0, 31) == 0) busy_len = $urandom_range(2, 6);
         tick();
      end
      ack_mode = 1;
      drain(500);

      // reset asserted mid-write
      ack_mode = 0;
      c = 8'($urandom);
      push(c);
      tick();
      check("pre_rst_req", u_req, 1);
      #2;
      io_rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs("rst_mid");
      @(posedge io_clk); #1;
      io_rst = 1'b0;
      ack_mode = 1;
      repeat (3) tick();
      check("post_rst_req", u_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
